// File: rtl/timer_pwm_multi.sv
// Multi-channel timer/PWM generator: prescaled edge- or center-aligned counter
// with double-buffered period/compare/mode settings and registered PWM outputs.
module timer_pwm_multi #(
  parameter int COUNTER_BITS   = 16,
  parameter int NUM_CHANNELS   = 4,
  parameter int PRESCALER_BITS = 8
) (
  input  logic                                 i_clock,
  input  logic                                 i_reset,
  input  logic                                 i_enable,
  input  logic [PRESCALER_BITS-1:0]            i_prescale,
  input  logic                                 i_mode,
  input  logic [COUNTER_BITS-1:0]              i_top_value,
  input  logic [NUM_CHANNELS*COUNTER_BITS-1:0] i_compare_values,
  input  logic                                 i_update_request,
  output logic [COUNTER_BITS-1:0]              o_counter_value,
  output logic                                 o_direction,
  output logic                                 o_overflow,
  output logic [NUM_CHANNELS-1:0]              o_compare_match,
  output logic [NUM_CHANNELS-1:0]              o_pwm_out
);

  localparam int CW = COUNTER_BITS;
  localparam int NW = NUM_CHANNELS * COUNTER_BITS;
  localparam int PW = PRESCALER_BITS;

  logic [PW-1:0]           r_stg_presc, r_act_presc, r_presc_cnt;
  logic                    r_stg_mode, r_act_mode;
  logic [CW-1:0]           r_stg_top, r_act_top;
  logic [NW-1:0]           r_stg_cmp, r_act_cmp;
  logic                    r_pending;
  logic [CW-1:0]           r_counter;
  logic                    r_dir;
  logic                    r_overflow;
  logic [NUM_CHANNELS-1:0] r_match, r_pwm;

  logic                    w_tick, w_boundary, w_wrap, w_reload, w_restart;
  logic [CW-1:0]           w_cnt_next;
  logic                    w_dir_next;
  logic [PW-1:0]           w_src_presc;
  logic                    w_src_mode;
  logic [CW-1:0]           w_src_top;
  logic [NW-1:0]           w_src_cmp, w_new_cmp;
  logic [NUM_CHANNELS-1:0] w_match, w_pwm;

  always_comb begin
    w_tick     = i_enable && (r_presc_cnt >= r_act_presc);
    w_cnt_next = r_counter;
    w_dir_next = r_dir;
    w_boundary = 1'b0;
    // Next counter step under the active settings; >= guards keep it in range
    // after an enable-low reload left the counter sitting on the new top.
    if (r_act_top == '0) begin
      w_cnt_next = '0;
      w_dir_next = 1'b0;
      w_boundary = 1'b1;
    end else if (!r_act_mode) begin
      w_dir_next = 1'b0;
      if (r_counter >= r_act_top) begin
        w_cnt_next = '0;
        w_boundary = 1'b1;
      end else begin
        w_cnt_next = r_counter + CW'(1);
      end
    end else if (!r_dir && (r_counter < r_act_top)) begin
      w_cnt_next = r_counter + CW'(1);
      w_dir_next = (w_cnt_next == r_act_top);
    end else if (r_counter <= CW'(1)) begin
      w_cnt_next = '0;
      w_dir_next = 1'b0;
      w_boundary = 1'b1;
    end else begin
      w_cnt_next = r_counter - CW'(1);
      w_dir_next = 1'b1;
    end
    w_wrap = w_tick && w_boundary;

    // A request coinciding with a reload bypasses staging.
    w_src_presc = i_update_request ? i_prescale       : r_stg_presc;
    w_src_mode  = i_update_request ? i_mode           : r_stg_mode;
    w_src_top   = i_update_request ? i_top_value      : r_stg_top;
    w_src_cmp   = i_update_request ? i_compare_values : r_stg_cmp;
    w_reload    = (w_wrap && (r_pending || i_update_request)) || (!i_enable && r_pending);
    w_new_cmp   = w_reload ? w_src_cmp : r_act_cmp;
    w_restart   = w_reload && !i_enable &&
                  ((w_src_mode != r_act_mode) || (r_counter > w_src_top));

    w_match = '0;
    w_pwm   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_match[i] = (w_cnt_next == w_new_cmp[i*CW +: CW]);
      w_pwm[i]   = (w_cnt_next <  w_new_cmp[i*CW +: CW]);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stg_presc <= '0;
      r_stg_mode  <= 1'b0;
      r_stg_top   <= '0;
      r_stg_cmp   <= '0;
      r_act_presc <= '0;
      r_act_mode  <= 1'b0;
      r_act_top   <= '0;
      r_act_cmp   <= '0;
      r_pending   <= 1'b0;
      r_presc_cnt <= '0;
      r_counter   <= '0;
      r_dir       <= 1'b0;
      r_overflow  <= 1'b0;
      r_match     <= '0;
      r_pwm       <= '0;
    end else begin
      if (i_update_request) begin
        r_stg_presc <= i_prescale;
        r_stg_mode  <= i_mode;
        r_stg_top   <= i_top_value;
        r_stg_cmp   <= i_compare_values;
      end
      r_pending <= w_reload ? 1'b0 : (i_update_request ? 1'b1 : r_pending);
      if (w_reload) begin
        r_act_presc <= w_src_presc;
        r_act_mode  <= w_src_mode;
        r_act_top   <= w_src_top;
        r_act_cmp   <= w_src_cmp;
      end
      if (i_enable) r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PW'(1);
      r_overflow <= w_wrap;
      r_match    <= '0;
      if (w_tick) begin
        r_counter <= w_cnt_next;
        r_dir     <= w_dir_next;
        r_match   <= w_match;
        r_pwm     <= w_pwm;
      end else if (w_restart) begin
        r_counter <= '0;
        r_dir     <= 1'b0;
      end
    end
  end

  assign o_counter_value = r_counter;
  assign o_direction     = r_dir;
  assign o_overflow      = r_overflow;
  assign o_compare_match = r_match;
  assign o_pwm_out       = r_pwm;

endmodule

// File: tb/tb_timer_pwm_multi.sv
// Bench for timer_pwm_multi: directed scenarios plus random traffic, every
// cycle checked against a phase-index reference model through an expected queue.
module tb_timer_pwm_multi;

  localparam int CW = 16;
  localparam int NC = 4;
  localparam int PW = 8;
  localparam int EW = CW + 2 + 2 * NC;

  logic            clk = 1'b0;
  logic            rst, en, mode, upd;
  logic [PW-1:0]   presc;
  logic [CW-1:0]   top;
  logic [NC*CW-1:0] cmpv;
  logic [CW-1:0]   cnt_o;
  logic            dir_o, ovf_o;
  logic [NC-1:0]   match_o, pwm_o;

  timer_pwm_multi #(.COUNTER_BITS(CW), .NUM_CHANNELS(NC), .PRESCALER_BITS(PW)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_prescale(presc), .i_mode(mode),
    .i_top_value(top), .i_compare_values(cmpv), .i_update_request(upd),
    .o_counter_value(cnt_o), .o_direction(dir_o), .o_overflow(ovf_o),
    .o_compare_match(match_o), .o_pwm_out(pwm_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  bit run = 1'b1;
  bit started = 1'b0;

  // ---------------- reference model ----------------
  // The counter is tracked as a position p within the period; counter value and
  // direction are derived from p arithmetically.
  int s_presc, s_mode, s_top, s_cmp[NC];
  int a_presc, a_mode, a_top, a_cmp[NC];
  int m_pc, m_p, m_c, m_dir, m_pend;
  bit m_ovf;
  bit [NC-1:0] m_match, m_pwm;

  function automatic int period_of(int md, int t);
    if (t == 0) return 1;
    return md ? 2 * t : t + 1;
  endfunction

  function automatic int cnt_of(int md, int t, int p);
    if (md == 0) return p;
    return (p <= t) ? p : 2 * t - p;
  endfunction

  function automatic int dir_of(int md, int t, int p);
    return (md != 0 && t > 0 && p >= t) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    if (run) begin
      int in_presc, in_mode, in_top, in_cmp[NC];
      int src_presc, src_mode, src_top, src_cmp[NC];
      int old_mode;
      bit tick, wrap, reload;
      in_presc = int'(presc);
      in_mode  = int'(mode);
      in_top   = int'(top);
      for (int i = 0; i < NC; i++) in_cmp[i] = int'(cmpv[i*CW +: CW]);
      if (rst) begin
        s_presc = 0; s_mode = 0; s_top = 0;
        a_presc = 0; a_mode = 0; a_top = 0;
        for (int i = 0; i < NC; i++) begin s_cmp[i] = 0; a_cmp[i] = 0; end
        m_pc = 0; m_p = 0; m_c = 0; m_dir = 0; m_pend = 0;
        m_ovf = 0; m_match = '0; m_pwm = '0;
      end else begin
        tick = en && (m_pc >= a_presc);
        if (en) m_pc = tick ? 0 : m_pc + 1;
        wrap = tick && (m_p + 1 >= period_of(a_mode, a_top));
        src_presc = upd ? in_presc : s_presc;
        src_mode  = upd ? in_mode  : s_mode;
        src_top   = upd ? in_top   : s_top;
        for (int i = 0; i < NC; i++) src_cmp[i] = upd ? in_cmp[i] : s_cmp[i];
        reload = (wrap && (m_pend != 0 || upd)) || (!en && m_pend != 0);
        if (tick) m_p = wrap ? 0 : m_p + 1;
        old_mode = a_mode;
        if (reload) begin
          a_presc = src_presc; a_mode = src_mode; a_top = src_top;
          for (int i = 0; i < NC; i++) a_cmp[i] = src_cmp[i];
          if (!en) begin
            if (a_mode != old_mode || m_c > a_top) begin
              m_p = 0; m_c = 0; m_dir = 0;
            end else begin
              m_p = m_dir ? 2 * a_top - m_c : m_c;
            end
          end
        end
        if (tick) begin
          m_c   = cnt_of(a_mode, a_top, m_p);
          m_dir = dir_of(a_mode, a_top, m_p);
          m_ovf = wrap;
          for (int i = 0; i < NC; i++) begin
            m_match[i] = (m_c == a_cmp[i]);
            m_pwm[i]   = (m_c <  a_cmp[i]);
          end
        end else begin
          m_ovf = 1'b0;
          m_match = '0;
        end
        if (upd) begin
          s_presc = in_presc; s_mode = in_mode; s_top = in_top;
          for (int i = 0; i < NC; i++) s_cmp[i] = in_cmp[i];
        end
        m_pend = reload ? 0 : (upd ? 1 : m_pend);
      end
      exp_q.push_back({CW'(m_c), m_dir[0], m_ovf, m_match, m_pwm});
      started = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (started) begin
      if (exp_q.size() == 0) begin
        if (run) begin
          n_checks++;
          n_errors++;
          $display("FAIL queue_underflow at %0t: got empty queue, required an expected entry", $time);
        end
      end else begin
        logic [EW-1:0] e, a;
        e = exp_q.pop_front();
        a = {cnt_o, dir_o, ovf_o, match_o, pwm_o};
        n_checks++;
        if (a !== e) begin
          n_errors++;
          if (n_errors <= 20)
            $display("FAIL outputs at %0t: got cnt=%0d dir=%0b ovf=%0b match=%b pwm=%b, required cnt=%0d dir=%0b ovf=%0b match=%b pwm=%b",
                     $time, a[EW-1 -: CW], a[2*NC+1], a[2*NC], a[2*NC-1 -: NC], a[NC-1:0],
                     e[EW-1 -: CW], e[2*NC+1], e[2*NC], e[2*NC-1 -: NC], e[NC-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_update(input int p, input int md, input int t,
                           input int c0, input int c1, input int c2, input int c3);
    @(negedge clk);
    presc = PW'(p);
    mode  = md[0];
    top   = CW'(t);
    cmpv  = {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    upd   = 1'b1;
    @(negedge clk);
    upd   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; upd = 1'b0;
    presc = '0; top = '0; cmpv = '0;
    idle(3);
    rst = 1'b0;

    // edge mode, prescale 0, top 4, compares {0,2,4,5}, loaded while disabled
    do_update(0, 0, 4, 0, 2, 4, 5);
    idle(2);
    en = 1'b1;
    idle(30);

    // prescale 2, top 1
    do_update(2, 0, 1, 0, 1, 2, 1);
    idle(30);

    // center mode, top 3, compare[0]=2
    do_update(0, 1, 3, 2, 0, 3, 4);
    idle(40);

    // mid-period reload 9 -> 3, then two requests in one period
    do_update(0, 0, 9, 5, 9, 0, 10);
    idle(25);
    do_update(0, 0, 3, 1, 3, 2, 4);
    idle(12);
    do_update(0, 0, 6, 4, 1, 1, 1);
    idle(2);
    do_update(0, 0, 5, 2, 5, 0, 6);
    idle(20);

    // enable low mid-period
    idle(3);
    en = 1'b0;
    idle(10);
    en = 1'b1;
    idle(20);

    // reset mid-count in center mode, then reload while disabled
    do_update(0, 1, 5, 3, 5, 0, 1);
    idle(20);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    en = 1'b0;
    do_update(1, 1, 4, 2, 4, 0, 5);
    idle(3);
    en = 1'b1;
    idle(30);

    // random traffic
    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 399) == 0);
      upd = ($urandom_range(0, 29) == 0);
      if (upd) begin
        presc = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(1, 3)) : '0;
        mode  = 1'($urandom_range(0, 1));
        top   = CW'($urandom_range(0, 9));
        for (int i = 0; i < NC; i++) cmpv[i*CW +: CW] = CW'($urandom_range(0, 11));
      end
    end
    @(negedge clk);
    rst = 1'b0; upd = 1'b0;

    @(negedge clk);
    run = 1'b0;
    idle(3);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
